// File: rtl/minirv_control_pkg.sv
// Shared types and constants for the miniRV multi-cycle control sequencer:
// FSM state encoding, supported opcodes and writeback-select encodings.
package minirv_control_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH     = 3'd0,
        STATE_DECODE    = 3'd1,
        STATE_EXECUTE   = 3'd2,
        STATE_MEMORY    = 3'd3,
        STATE_WRITEBACK = 3'd4,
        STATE_TRAP      = 3'd5
    } control_state_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam logic [1:0] WB_SEL_ALU       = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD      = 2'b01;
    localparam logic [1:0] WB_SEL_PC_PLUS_4 = 2'b10;
    localparam logic [1:0] WB_SEL_U_IMM     = 2'b11;

    function automatic logic is_supported_opcode(input logic [6:0] op);
        case (op)
            OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD,
            OPCODE_STORE, OPCODE_LUI, OPCODE_JALR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic is_memory_opcode(input logic [6:0] op);
        return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
    endfunction

    function automatic logic uses_immediate_operand(input logic [6:0] op);
        case (op)
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_JALR: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] writeback_select_for(input logic [6:0] op);
        case (op)
            OPCODE_LOAD: return WB_SEL_LOAD;
            OPCODE_JALR: return WB_SEL_PC_PLUS_4;
            OPCODE_LUI:  return WB_SEL_U_IMM;
            default:     return WB_SEL_ALU;
        endcase
    endfunction

endpackage

// File: rtl/memory_wait_timer.sv
// Counts cycles spent waiting on a data-memory handshake and flags the cycle
// in which the wait reaches MEMORY_WAIT_LIMIT (0 disables the flag).
module memory_wait_timer #(
    parameter int unsigned MEMORY_WAIT_LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic limit_reached_o
);

    // The counter holds the number of earlier waiting cycles, so the Nth cycle
    // of the wait sees N-1 and is the one that reports the limit.
    localparam int unsigned LAST_COUNT = (MEMORY_WAIT_LIMIT == 0) ? 0 : MEMORY_WAIT_LIMIT - 1;
    localparam int unsigned COUNT_W    = (LAST_COUNT < 2) ? 1 : $clog2(LAST_COUNT + 1);
    localparam logic [COUNT_W-1:0] LAST_COUNT_W = COUNT_W'(LAST_COUNT);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // NOTE: next-state logic assigns a default first so no path leaves count_d
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST_COUNT_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign limit_reached_o = (MEMORY_WAIT_LIMIT != 0) && (count_q == LAST_COUNT_W);

endmodule

// File: rtl/multicycle_control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM for miniRV.
// Define MINIRV_RETIRE_COUNTER_EN to build the retired-instruction counter.
module multicycle_control_sequencer
    import minirv_control_pkg::*;
#(
    parameter int unsigned MEMORY_WAIT_LIMIT    = 255,
    parameter int unsigned RETIRE_COUNTER_WIDTH = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [6:0]                      opcode,
    input  logic                            instruction_ready,
    input  logic                            data_ready,
    output logic                            instruction_request,
    output logic                            instruction_register_write_enable,
    output logic                            data_read_request,
    output logic                            data_write_request,
    output logic                            register_file_write_enable,
    output logic                            pc_write_enable,
    output logic                            pc_source_select,
    output logic                            alu_source_select,
    output logic [1:0]                      writeback_select,
    output logic                            illegal_instruction,
    output logic                            bus_error,
    output logic                            halted,
    output logic [2:0]                      current_state,
    output logic [RETIRE_COUNTER_WIDTH-1:0] retired_instruction_count
);

    control_state_t state_q;
    control_state_t state_d;
    logic [6:0]     opcode_q;
    logic [6:0]     opcode_d;
    logic           illegal_q;
    logic           illegal_d;
    logic           bus_error_q;
    logic           bus_error_d;
    logic           wait_limit_reached;

    memory_wait_timer #(
        .MEMORY_WAIT_LIMIT(MEMORY_WAIT_LIMIT)
    ) u_memory_wait_timer (
        .clock          (clock),
        .reset          (reset),
        .clear_i        (state_q != STATE_MEMORY),
        .enable_i       (state_q == STATE_MEMORY),
        .limit_reached_o(wait_limit_reached)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        case (state_q)
            STATE_FETCH: begin
                if (instruction_ready) begin
                    state_d = STATE_DECODE;
                end
            end
            STATE_DECODE: begin
                opcode_d = opcode;
                if (is_supported_opcode(opcode)) begin
                    state_d = STATE_EXECUTE;
                end else begin
                    state_d   = STATE_TRAP;
                    illegal_d = 1'b1;
                end
            end
            STATE_EXECUTE: begin
                state_d = is_memory_opcode(opcode_q) ? STATE_MEMORY : STATE_WRITEBACK;
            end
            STATE_MEMORY: begin
                // A ready arriving in the limit cycle wins over the timeout.
                if (data_ready) begin
                    state_d = (opcode_q == OPCODE_LOAD) ? STATE_WRITEBACK : STATE_FETCH;
                end else if (wait_limit_reached) begin
                    state_d     = STATE_TRAP;
                    bus_error_d = 1'b1;
                end
            end
            STATE_WRITEBACK: state_d = STATE_FETCH;
            STATE_TRAP:      state_d = STATE_TRAP;
            default:         state_d = STATE_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= STATE_FETCH;
            opcode_q    <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Moore decode of the state; only the IR load and the store-completion PC
    // write look at the ready inputs. Reset blanks every output.
    always_comb begin
        instruction_request               = 1'b0;
        instruction_register_write_enable = 1'b0;
        data_read_request                 = 1'b0;
        data_write_request                = 1'b0;
        register_file_write_enable        = 1'b0;
        pc_write_enable                   = 1'b0;
        pc_source_select                  = 1'b0;
        alu_source_select                 = 1'b0;
        writeback_select                  = WB_SEL_ALU;
        if (!reset) begin
            case (state_q)
                STATE_FETCH: begin
                    instruction_request               = 1'b1;
                    instruction_register_write_enable = instruction_ready;
                end
                STATE_EXECUTE: begin
                    alu_source_select = uses_immediate_operand(opcode_q);
                end
                STATE_MEMORY: begin
                    data_read_request  = (opcode_q == OPCODE_LOAD);
                    data_write_request = (opcode_q == OPCODE_STORE);
                    pc_write_enable    = (opcode_q == OPCODE_STORE) && data_ready;
                end
                STATE_WRITEBACK: begin
                    register_file_write_enable = 1'b1;
                    pc_write_enable            = 1'b1;
                    pc_source_select           = (opcode_q == OPCODE_JALR);
                    writeback_select           = writeback_select_for(opcode_q);
                end
                default: ;
            endcase
        end
    end

    assign illegal_instruction = !reset && illegal_q;
    assign bus_error           = !reset && bus_error_q;
    assign halted              = !reset && (state_q == STATE_TRAP);
    assign current_state       = reset ? 3'd0 : state_q;

`ifdef MINIRV_RETIRE_COUNTER_EN
    logic [RETIRE_COUNTER_WIDTH-1:0] retired_q;
    logic                            retire;

    assign retire = (state_q == STATE_WRITEBACK) ||
                    ((state_q == STATE_MEMORY) && (opcode_q == OPCODE_STORE) && data_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired_instruction_count = reset ? '0 : retired_q;
`else
    assign retired_instruction_count = '0;
`endif

endmodule

// File: doc/multicycle_control_sequencer.md
# multicycle_control_sequencer

Multi-cycle control FSM for the miniRV core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the enable and select lines of the PC, instruction register, ALU, register file and data-memory port, and performs valid/ready handshakes with instruction and data memory. It sits between the instruction decoder's `opcode` output and the datapath, and traps on unsupported opcodes or memory stalls that exceed a limit.

## Interface
- `MEMORY_WAIT_LIMIT`, default 255: maximum number of cycles a single MEMORY-state handshake may wait. 0 disables the limit.
- `RETIRE_COUNTER_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  decoder opcode for the current instruction register contents.
- `instruction_ready`  in  1  instruction memory has the word available this cycle.
- `data_ready`  in  1  data memory has completed the read or write this cycle.
- `instruction_request`  out  1  fetch request.
- `instruction_register_write_enable`  out  1  load the IR.
- `data_read_request`  out  1  load access.
- `data_write_request`  out  1  store access.
- `register_file_write_enable`  out  1  write `rd`.
- `pc_write_enable`  out  1  update the PC.
- `pc_source_select`  out  1  0 = PC+4; 1 = ALU result with bit0 cleared (JALR).
- `alu_source_select`  out  1  0 = rs2; 1 = immediate.
- `writeback_select`  out  2  00 = ALU; 01 = load data; 10 = PC+4; 11 = U-immediate.
- `illegal_instruction`  out  1  sticky trap cause.
- `bus_error`  out  1  sticky trap cause.
- `halted`  out  1  FSM is in TRAP.
- `current_state`  out  3  debug encoding of the FSM state.
- `retired_instruction_count`  out  `RETIRE_COUNTER_WIDTH`  number of retired instructions.

## Operation
- Supported opcodes:
  - OP 0110011
  - OP-IMM 0010011
  - LOAD 0000011
  - STORE 0100011
  - LUI 0110111
  - JALR 1100111
- Any other opcode is illegal.
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
- FETCH:
  - `instruction_request`=1.
  - On `instruction_ready`: `instruction_register_write_enable`=1 in the same cycle, go to DECODE. Otherwise stay.
- DECODE:
  - `opcode` is latched into the internal opcode register.
  - Illegal opcode: go to TRAP and set `illegal_instruction`. Otherwise go to EXECUTE.
- EXECUTE:
  - `alu_source_select`=1 for OP-IMM, LOAD, STORE and JALR; 0 otherwise.
  - LOAD or STORE: go to MEMORY. Otherwise go to WRITEBACK.
- MEMORY:
  - Hold `data_read_request` (LOAD) or `data_write_request` (STORE) until `data_ready`.
  - LOAD completes: go to WRITEBACK.
  - STORE completes: `pc_write_enable`=1 with source PC+4, retire, go to FETCH.
  - Wait counter runs from 0 on entry. If it reaches `MEMORY_WAIT_LIMIT` without `data_ready`, drop the request, set `bus_error`, go to TRAP.
  - `data_ready` in the same cycle the limit is reached counts as success.
- WRITEBACK:
  - `register_file_write_enable`=1 and `pc_write_enable`=1.
  - `writeback_select`: OP/OP-IMM=00, LOAD=01, JALR=10, LUI=11.
  - `pc_source_select`=1 only for JALR.
  - Retire, then go to FETCH.
- TRAP:
  - Absorbing until `reset`; all request and enable outputs are 0; `halted`=1.
- Select outputs are 0 outside the states listed above.
- Retire means `retired_instruction_count` increments by 1 and wraps modulo 2^`RETIRE_COUNTER_WIDTH`.

## Timing
- `reset` is sampled on a clock edge:
  - state becomes FETCH;
  - the opcode register, wait counter, trap flags and counter clear to 0;
  - while `reset` is high, every output is forced to 0, including `instruction_request` and `current_state`.
- Reset mid-MEMORY: request outputs drop to 0 in the cycle `reset` is high, with no retire. The next cycle after `reset` deasserts is FETCH.
- Outputs are Moore-decoded from the state, except the Mealy IR write and the STORE-completion PC write, which are gated by the ready inputs.
- Minimum latency, with ready inputs high on first request:
  - OP/OP-IMM/LUI/JALR: 4 cycles;
  - LOAD: 5 cycles;
  - STORE: 4 cycles.
- Each cycle of `instruction_ready`=0 or `data_ready`=0 adds one cycle.
- Ready inputs outside FETCH or MEMORY are ignored.

## Configuration
- `MINIRV_RETIRE_COUNTER_EN` defined: counter register present, behaving as described above.
- Not defined: no counter register; `retired_instruction_count` is tied to 0. All other behaviour is identical.

## Structure
- Package `minirv_control_pkg` holds:
  - the `control_state_t` enum;
  - opcode constants (`OPCODE_OP`, `OPCODE_OP_IMM`, `OPCODE_LOAD`, `OPCODE_STORE`, `OPCODE_LUI`, `OPCODE_JALR`);
  - `writeback_select` encodings.
- One sub-module, `memory_wait_timer`: a clear/enable counter with a `limit_reached` output, parameterised by `MEMORY_WAIT_LIMIT`.

## Test plan
- ADDI (opcode 0010011), both ready inputs held high:
  - states FETCH, DECODE, EXECUTE, WRITEBACK in 4 cycles;
  - `alu_source_select`=1 in EXECUTE;
  - in WRITEBACK: `writeback_select`=00, one `register_file_write_enable` pulse, one `pc_write_enable` pulse;
  - count 0→1.
- LW with `data_ready` rising on the 3rd MEMORY cycle:
  - `data_read_request` held for exactly 3 cycles;
  - total latency 7 cycles;
  - `writeback_select`=01.
- SW (0100011) with `data_ready`=1:
  - `pc_write_enable` in the MEMORY cycle;
  - `register_file_write_enable` never asserted;
  - back to FETCH after 4 cycles.
- Opcode 1101111 (JAL):
  - TRAP after DECODE; `illegal_instruction`=1 and `halted`=1;
  - no enables thereafter for 20 cycles;
  - `reset` returns the FSM to FETCH with the flags cleared.
- `MEMORY_WAIT_LIMIT`=8, LOAD with `data_ready`=0:
  - `bus_error` set after 8 MEMORY cycles, then TRAP;
  - repeat with `data_ready` on cycle 8: completes without error.
- `reset` asserted during the 2nd MEMORY cycle of a STORE:
  - outputs 0 in that cycle;
  - FETCH in the next cycle;
  - `retired_instruction_count`=0.
